// File: rtl/imm_pkg.sv
// FlowLine immediate generator shared definitions.
// Format select encodings and the sign-extension helper.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'd0;
  localparam logic [2:0] IMM_B   = 3'd1;
  localparam logic [2:0] IMM_J   = 3'd2;
  localparam logic [2:0] IMM_S   = 3'd3;
  localparam logic [2:0] IMM_U   = 3'd4;
  localparam logic [2:0] IMM_Z   = 3'd5;
  localparam logic [2:0] IMM_SH  = 3'd6;
  localparam logic [2:0] IMM_BAD = 3'd7;

  // Sign-extend the low w bits of v to 64 bits; callers narrow to XLEN.
  function automatic logic [63:0] sext_to_xlen(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [63:0] t;
    t = {32'b0, v} << (64 - w);
    return 64'($signed(t) >>> (64 - w));
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator.
// Input beat {inst,op,tag} in, output beat {imm,tag,illegal} out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_inst, in_op, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_imm, out_tag, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_op, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_imm, out_tag, out_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder for all RV formats.
// Only inst[31:7] carry immediate bits, so only those come in.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Select the format; shamt bit 25 is only legal on RV64.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == IMM_I): imm = XLEN'(sext_to_xlen(
        {20'b0, inst[31:20]}, 12));
      (op == IMM_B): imm = XLEN'(sext_to_xlen(
        {19'b0, inst[31], inst[7], inst[30:25],
         inst[11:8], 1'b0}, 13));
      (op == IMM_J): imm = XLEN'(sext_to_xlen(
        {11'b0, inst[31], inst[19:12], inst[20],
         inst[30:21], 1'b0}, 21));
      (op == IMM_S): imm = XLEN'(sext_to_xlen(
        {20'b0, inst[31:25], inst[11:7]}, 12));
      (op == IMM_U): imm = XLEN'(sext_to_xlen(
        {inst[31:12], 12'b0}, 32));
      (op == IMM_Z): imm = XLEN'(inst[19:15]);
      (op == IMM_SH): begin
        if (XLEN == 64) begin
          imm = XLEN'(inst[25:20]);
        end else begin
          imm     = XLEN'(inst[24:20]);
          illegal = inst[25];
        end
      end
      (op == IMM_BAD): illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer.
// Decode feeds the buffer; in_ready is registered, never from out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic      cpu_clk,
  input  logic      cpu_rst_n,
  input  logic      flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t          mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [1:0]      count_nxt;
  logic            ready_q;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic            push;
  logic            pop;

  imm_decode #(
    .XLEN (XLEN)
  ) u_dec (
    .inst    (bus.in_inst[31:7]),
    .op      (bus.in_op),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign push = bus.in_valid && ready_q && !flush;
  assign pop  = (count != 2'd0) && bus.out_ready && !flush;

  // Occupancy after this edge; flush empties the buffer outright.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end
  end

  // Buffer storage, pointers, occupancy and registered ready.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{imm:     dec_imm,
                         tag:     bus.in_tag,
                         illegal: dec_ill};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count   <= count_nxt;
      ready_q <= (count_nxt != 2'd2);
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_imm     = mem[rd_ptr].imm;
  assign bus.out_tag     = mem[rd_ptr].tag;
  assign bus.out_illegal = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe.
// One RV32 and one RV64 instance share clock, reset and flush.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .flush     (flush),
    .bus       (b32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .flush     (flush),
    .bus       (b64)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat32(input string n,
                        input logic [31:0] inst,
                        input logic [2:0]  op,
                        input logic [31:0] tag,
                        input logic [31:0] eimm,
                        input logic        eill);
    b32.in_inst   = inst;
    b32.in_op     = op;
    b32.in_tag    = tag;
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    check({n, "_v"}, 64'(b32.out_valid), 64'd1);
    check({n, "_imm"}, 64'(b32.out_imm), 64'(eimm));
    check({n, "_ill"}, 64'(b32.out_illegal), 64'(eill));
    check({n, "_tag"}, 64'(b32.out_tag), 64'(tag));
    tick();
    check({n, "_e"}, 64'(b32.out_valid), 64'd0);
  endtask

  task automatic beat64(input string n,
                        input logic [31:0] inst,
                        input logic [2:0]  op,
                        input logic [31:0] tag,
                        input logic [63:0] eimm,
                        input logic        eill);
    b64.in_inst   = inst;
    b64.in_op     = op;
    b64.in_tag    = tag;
    b64.in_valid  = 1'b1;
    b64.out_ready = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    check({n, "_v"}, 64'(b64.out_valid), 64'd1);
    check({n, "_imm"}, b64.out_imm, eimm);
    check({n, "_ill"}, 64'(b64.out_illegal), 64'(eill));
    check({n, "_tag"}, 64'(b64.out_tag), 64'(tag));
    tick();
    check({n, "_e"}, 64'(b64.out_valid), 64'd0);
  endtask

  initial begin
    b32.in_valid  = 1'b0;
    b32.in_inst   = '0;
    b32.in_op     = '0;
    b32.in_tag    = '0;
    b32.out_ready = 1'b0;
    b64.in_valid  = 1'b0;
    b64.in_inst   = '0;
    b64.in_op     = '0;
    b64.in_tag    = '0;
    b64.out_ready = 1'b0;
    #1;
    check("rst_v", 64'(b32.out_valid), 64'd0);
    check("rst_imm", 64'(b32.out_imm), 64'd0);
    check("rst_tag", 64'(b32.out_tag), 64'd0);
    check("rst_ill", 64'(b32.out_illegal), 64'd0);
    check("rst64_v", 64'(b64.out_valid), 64'd0);
    #20;
    rst_n = 1'b1;
    tick();
    check("rdy_after_rst", 64'(b32.in_ready), 64'd1);

    beat32("i32", 32'hFFF00093, IMM_I, 32'h100,
           32'hFFFFFFFF, 1'b0);
    beat32("b32", 32'hFE000EE3, IMM_B, 32'h104,
           32'hFFFFFFFC, 1'b0);
    beat32("j32", 32'h0080006F, IMM_J, 32'h108,
           32'h00000008, 1'b0);
    beat32("s32", 32'hFE112E23, IMM_S, 32'h10C,
           32'hFFFFFFFC, 1'b0);
    beat32("u32", 32'h800000B7, IMM_U, 32'h110,
           32'h80000000, 1'b0);
    beat32("z32", 32'h340FD073, IMM_Z, 32'h114,
           32'h0000001F, 1'b0);
    beat32("sh32", 32'h01F0D093, IMM_SH, 32'h118,
           32'h0000001F, 1'b0);
    beat32("bad32", 32'h12345678, IMM_BAD, 32'h11C,
           32'h00000000, 1'b1);
    beat32("shx32", 32'h0200D093, IMM_SH, 32'h120,
           32'h00000000, 1'b1);

    beat64("u64", 32'h800000B7, IMM_U, 32'h200,
           64'hFFFFFFFF80000000, 1'b0);
    beat64("sh64", 32'h03F0D093, IMM_SH, 32'h204,
           64'h000000000000003F, 1'b0);
    beat64("z64", 32'h340FD073, IMM_Z, 32'h208,
           64'h000000000000001F, 1'b0);
    beat64("i64", 32'hFFF00093, IMM_I, 32'h20C,
           64'hFFFFFFFFFFFFFFFF, 1'b0);

    // backpressure: three beats against a stalled consumer
    b32.out_ready = 1'b0;
    b32.in_inst   = 32'h00100093;
    b32.in_op     = IMM_I;
    b32.in_tag    = 32'd1;
    b32.in_valid  = 1'b1;
    tick();
    check("bp1_rdy", 64'(b32.in_ready), 64'd1);
    check("bp1_tag", 64'(b32.out_tag), 64'd1);
    b32.in_tag = 32'd2;
    tick();
    check("bp2_rdy", 64'(b32.in_ready), 64'd0);
    check("bp2_tag", 64'(b32.out_tag), 64'd1);
    b32.in_tag = 32'd3;
    tick();
    check("bp3_rdy", 64'(b32.in_ready), 64'd0);
    check("bp3_v", 64'(b32.out_valid), 64'd1);
    check("bp3_tag", 64'(b32.out_tag), 64'd1);
    check("bp3_imm", 64'(b32.out_imm), 64'd1);
    b32.out_ready = 1'b1;
    tick();
    check("dr1_v", 64'(b32.out_valid), 64'd1);
    check("dr1_tag", 64'(b32.out_tag), 64'd2);
    check("dr1_rdy", 64'(b32.in_ready), 64'd1);
    tick();
    check("dr2_v", 64'(b32.out_valid), 64'd1);
    check("dr2_tag", 64'(b32.out_tag), 64'd3);
    b32.in_valid = 1'b0;
    tick();
    check("dr3_v", 64'(b32.out_valid), 64'd0);

    // flush with two beats buffered and a beat offered
    b32.out_ready = 1'b0;
    b32.in_inst   = 32'hFFF00093;
    b32.in_tag    = 32'hA1;
    b32.in_valid  = 1'b1;
    tick();
    b32.in_tag = 32'hA2;
    tick();
    check("fl_pre_v", 64'(b32.out_valid), 64'd1);
    check("fl_pre_rdy", 64'(b32.in_ready), 64'd0);
    b32.in_tag = 32'hA3;
    flush      = 1'b1;
    tick();
    flush        = 1'b0;
    b32.in_valid = 1'b0;
    check("fl_v", 64'(b32.out_valid), 64'd0);
    check("fl_rdy", 64'(b32.in_ready), 64'd1);
    tick();
    check("fl_drop_v", 64'(b32.out_valid), 64'd0);

    // asynchronous reset with beats buffered
    b32.in_tag   = 32'hB1;
    b32.in_valid = 1'b1;
    tick();
    b32.in_tag = 32'hB2;
    tick();
    b32.in_valid = 1'b0;
    check("ar_pre_tag", 64'(b32.out_tag), 64'hB1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_v", 64'(b32.out_valid), 64'd0);
    check("ar_imm", 64'(b32.out_imm), 64'd0);
    check("ar_tag", 64'(b32.out_tag), 64'd0);
    check("ar_ill", 64'(b32.out_illegal), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check("ar_rdy", 64'(b32.in_ready), 64'd1);
    check("ar_post_v", 64'(b32.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
